sa_controller: RTL and testbench
================================

# sa_controller

Sequencer for the systolic-array compute top. It accepts a job command (`start` + `num_rows`) and drives the load/out enables of the input, weight and output buffers plus `write_weight_en` of the array. It walks a fixed phase order: weight load, activation load, weight preload, compute, result unload. It sits between the host/command interface and the compute top, replacing the hand-driven enable pins.

## Interface

Parameters:
- ARRAYWIDTH, 8, array dimension; number of weight rows loaded and preloaded.
- MAX_ROWS, 64, largest legal activation row count per job.
- ROW_W, 7, width of `num_rows` (must hold MAX_ROWS).
- SA_LATENCY, 16, cycles from first `input_buffer_out_en` to first valid `out_sum` row.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  job request, sampled only in IDLE.
- num_rows  in  ROW_W  activation rows for the job, captured with `start`.
- skip_weights  in  1  captured with `start`; 1 = reuse the weights already in the array (skip LOAD_W and PRELOAD).
- abort  in  1  synchronous cancel, any state.
- input_buffer_load_en, input_buffer_out_en  out  1 each  input buffer controls.
- weight_buffer_load_en, weight_buffer_out_en  out  1 each  weight buffer controls.
- output_buffer_load_en, output_buffer_out_en  out  1 each  output buffer controls.
- write_weight_en  out  1  array weight-latch enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a job completes.
- err  out  1  one-cycle pulse when a command is rejected.

## Operation

- States: IDLE, LOAD_W, LOAD_A, PRELOAD, COMPUTE, UNLOAD, DONE. One shared phase counter, width ≥ clog2(SA_LATENCY+MAX_ROWS+1).
- IDLE + `start`: validate the command.
  - Reject if num_rows==0, num_rows>MAX_ROWS, or skip_weights=1 while `weights_valid`=0. On reject: pulse `err`, stay in IDLE.
  - On accept: latch N=num_rows and the skip flag. Go to LOAD_W, or to LOAD_A when skip=1.
- LOAD_W: `weight_buffer_load_en`=1 for ARRAYWIDTH cycles, then LOAD_A.
- LOAD_A: `input_buffer_load_en`=1 for N cycles. Then PRELOAD, or COMPUTE when skip=1.
- PRELOAD: `weight_buffer_out_en`=1 and `write_weight_en`=1 for ARRAYWIDTH cycles. On exit, set `weights_valid`=1, then go to COMPUTE.
- COMPUTE lasts SA_LATENCY+N cycles, with phase index c=0..SA_LATENCY+N-1.
  - `input_buffer_out_en`=1 for c<N.
  - `output_buffer_load_en`=1 for SA_LATENCY≤c<SA_LATENCY+N.
  - Both may be high together when N>SA_LATENCY.
- UNLOAD: `output_buffer_out_en`=1 for N cycles, then DONE.
- DONE: `done`=1 for one cycle, then IDLE. A `start` seen in DONE is ignored; the host must re-issue it in IDLE.
- `start` in any non-IDLE state is ignored, with no `err`.
- `abort`=1:
  - Next state is IDLE; all enables drop to 0 on the next edge. No `done`, no `err`.
  - Abort during PRELOAD clears `weights_valid`. Abort in any other state leaves it unchanged.
  - abort+start in IDLE: abort wins, the command is dropped.
- `weights_valid` is internal. It is cleared by reset and set only by a completed PRELOAD.
- Exactly one buffer's load/out pair is active per state, except COMPUTE as described above. `input_buffer_load_en` and `input_buffer_out_en` are never high together.

## Timing

- All outputs are registered and derived from the state and counter.
- Reset values: state=IDLE, counter=0, `weights_valid`=0, and every output 0 (all enables, busy, done, err).
- Reset asserted mid-job: outputs go to 0 immediately (asynchronously); the FSM restarts in IDLE after release.
- Cycle 0 is the cycle `start` is sampled high.
- First enable of the first phase is high in cycle 1. `busy` is high from cycle 1 through the DONE cycle inclusive.
- `err` is high in cycle 1 for a rejected command.
- Phases abut with no gap cycles.
- `done` cycle = 1 + 2·ARRAYWIDTH + N + (SA_LATENCY+N) + N, or 1 + 3N + SA_LATENCY when skip=1.
- A new `start` can be accepted in the cycle after DONE (IDLE).

## Test plan

- Reset, N=4, skip=0, default parameters. Required timing:
  - weight load cycles 1–8; input load 9–12; preload 13–20; input out 21–24; output load 37–40; unload 41–44.
  - `done` in cycle 45; `busy` low in cycle 46.
- After the previous job, N=4, skip=1. Required: input load 1–4, input out 5–8, output load 21–24, unload 25–28, `done` in cycle 29.
- Reset, then skip=1 → `err` in cycle 1 and `busy` stays 0. Also num_rows=0 → `err`, and num_rows=65 → `err`.
- N=20 (N>SA_LATENCY): `input_buffer_out_en` and `output_buffer_load_en` both high in COMPUTE c=16..19; `done` in cycle 1+16+20+36+20=93.
- `abort` in the 3rd PRELOAD cycle → all enables 0 next cycle, no `done`. A following skip=1 `start` → `err`.
- `rst`=0 in mid-COMPUTE → outputs 0 without a clock edge. After release, `start` with skip=1 → `err`.

Source files
------------

// File: rtl/sa_controller.sv
// Job sequencer for the systolic-array compute top: walks weight load, activation load,
// weight preload, compute and result unload, driving the buffer enables from registered state.
module sa_controller #(
  parameter int ARRAYWIDTH = 8,
  parameter int MAX_ROWS   = 64,
  parameter int ROW_W      = 7,
  parameter int SA_LATENCY = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] num_rows,
  input  logic             skip_weights,
  input  logic             abort,
  output logic             input_buffer_load_en,
  output logic             input_buffer_out_en,
  output logic             weight_buffer_load_en,
  output logic             weight_buffer_out_en,
  output logic             output_buffer_load_en,
  output logic             output_buffer_out_en,
  output logic             write_weight_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, PRELOAD, COMPUTE, UNLOAD, DONE} state_t;

  localparam int CNT_W = $clog2(SA_LATENCY + MAX_ROWS + 1);
  localparam logic [CNT_W-1:0] AW_LAST = CNT_W'(ARRAYWIDTH - 1);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(SA_LATENCY);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] n_q, n_n;
  logic             skip_q, skip_n;
  logic             wv, wv_n;
  logic             err_n;

  logic [CNT_W-1:0] phase_last;
  logic [CNT_W-1:0] n_ext, nn_ext;
  logic             cmd_bad;

  logic il_n, io_n, wl_n, wo_n, ol_n, oo_n, ww_n, busy_n, done_n;

  assign state_dbg = state;
  assign n_ext     = CNT_W'(n_q);
  assign nn_ext    = CNT_W'(n_n);
  assign cmd_bad   = (num_rows == '0) || (num_rows > ROW_W'(MAX_ROWS)) ||
                     (skip_weights && !wv);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      n_q                   <= '0;
      skip_q                <= 1'b0;
      wv                    <= 1'b0;
      input_buffer_load_en  <= 1'b0;
      input_buffer_out_en   <= 1'b0;
      weight_buffer_load_en <= 1'b0;
      weight_buffer_out_en  <= 1'b0;
      output_buffer_load_en <= 1'b0;
      output_buffer_out_en  <= 1'b0;
      write_weight_en       <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      err                   <= 1'b0;
    end else begin
      state                 <= state_n;
      cnt                   <= cnt_n;
      n_q                   <= n_n;
      skip_q                <= skip_n;
      wv                    <= wv_n;
      input_buffer_load_en  <= il_n;
      input_buffer_out_en   <= io_n;
      weight_buffer_load_en <= wl_n;
      weight_buffer_out_en  <= wo_n;
      output_buffer_load_en <= ol_n;
      output_buffer_out_en  <= oo_n;
      write_weight_en       <= ww_n;
      busy                  <= busy_n;
      done                  <= done_n;
      err                   <= err_n;
    end
  end

  // Last counter value of the current phase; every phase counts 0..last.
  always_comb begin
    phase_last = '0;
    case (state)
      LOAD_W, PRELOAD: phase_last = AW_LAST;
      LOAD_A, UNLOAD:  phase_last = n_ext - ONE;
      COMPUTE:         phase_last = LAT_C + n_ext - ONE;
      default:         phase_last = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    n_n     = n_q;
    skip_n  = skip_q;
    wv_n    = wv;
    err_n   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      if (state == PRELOAD) wv_n = 1'b0;
    end else begin
      if (state != IDLE && state != DONE) cnt_n = (cnt == phase_last) ? '0 : cnt + ONE;
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (start) begin
            if (cmd_bad) begin
              err_n = 1'b1;
            end else begin
              n_n     = num_rows;
              skip_n  = skip_weights;
              state_n = skip_weights ? LOAD_A : LOAD_W;
            end
          end
        end
        LOAD_W:  if (cnt == phase_last) state_n = LOAD_A;
        LOAD_A:  if (cnt == phase_last) state_n = skip_q ? COMPUTE : PRELOAD;
        PRELOAD: if (cnt == phase_last) begin
          state_n = COMPUTE;
          wv_n    = 1'b1;
        end
        COMPUTE: if (cnt == phase_last) state_n = UNLOAD;
        UNLOAD:  if (cnt == phase_last) state_n = DONE;
        DONE: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state/counter so the registered value lines up with the phase.
  always_comb begin
    il_n   = 1'b0;
    io_n   = 1'b0;
    wl_n   = 1'b0;
    wo_n   = 1'b0;
    ol_n   = 1'b0;
    oo_n   = 1'b0;
    ww_n   = 1'b0;
    done_n = 1'b0;
    busy_n = (state_n != IDLE);
    case (state_n)
      LOAD_W:  wl_n = 1'b1;
      LOAD_A:  il_n = 1'b1;
      PRELOAD: begin
        wo_n = 1'b1;
        ww_n = 1'b1;
      end
      COMPUTE: begin
        io_n = (cnt_n < nn_ext);
        ol_n = (cnt_n >= LAT_C) && (cnt_n < LAT_C + nn_ext);
      end
      UNLOAD:  oo_n = 1'b1;
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sa_controller.sv
// Directed bench for sa_controller: per-cycle enable windows for full, skip and overlap jobs,
// command rejection, abort during preload and asynchronous reset mid-job.
module tb_sa_controller;
  localparam int AW  = 8;
  localparam int LAT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] num_rows = '0;
  logic       skip_weights = 1'b0;
  logic       abort = 1'b0;
  logic       input_buffer_load_en, input_buffer_out_en;
  logic       weight_buffer_load_en, weight_buffer_out_en;
  logic       output_buffer_load_en, output_buffer_out_en;
  logic       write_weight_en, busy, done, err;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sa_controller dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .skip_weights(skip_weights), .abort(abort),
    .input_buffer_load_en(input_buffer_load_en), .input_buffer_out_en(input_buffer_out_en),
    .weight_buffer_load_en(weight_buffer_load_en), .weight_buffer_out_en(weight_buffer_out_en),
    .output_buffer_load_en(output_buffer_load_en), .output_buffer_out_en(output_buffer_out_en),
    .write_weight_en(write_weight_en), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // {wl, wo, ww, il, io, ol, oo, busy, done, err}
  function automatic logic [9:0] observed();
    return {weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
            input_buffer_load_en, input_buffer_out_en, output_buffer_load_en,
            output_buffer_out_en, busy, done, err};
  endfunction

  // Expected outputs in cycle c of a job started in cycle 0, from the phase windows.
  function automatic logic [9:0] exp_vec(int c, int n, bit skip);
    int il_s, pre_s, base, dn_c;
    logic wl, wo, il, io, ol, oo, bz, dn;
    il_s  = skip ? 1 : 1 + AW;
    pre_s = il_s + n;
    base  = skip ? il_s + n : pre_s + AW;
    dn_c  = base + LAT + 2 * n;
    wl = !skip && c >= 1 && c <= AW;
    il = c >= il_s && c < il_s + n;
    wo = !skip && c >= pre_s && c < pre_s + AW;
    io = c >= base && c < base + n;
    ol = c >= base + LAT && c < base + LAT + n;
    oo = c >= base + LAT + n && c < dn_c;
    dn = (c == dn_c);
    bz = c >= 1 && c <= dn_c;
    return {wl, wo, wo, il, io, ol, oo, bz, dn, 1'b0};
  endfunction

  task automatic issue(input int n, input bit skip);
    @(negedge clk);
    start        = 1'b1;
    num_rows     = 7'(n);
    skip_weights = skip;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (observed() !== 10'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state outputs=%b state=%0d required outputs=0 state=0", observed(), state_dbg);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_job(input string name, input int n, input bit skip, input int last_cyc);
    logic [9:0] exp;
    issue(n, skip);
    for (int c = 1; c <= last_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp = exp_vec(c, n, skip);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d got=%b expected=%b", name, c, observed(), exp);
      end
    end
  endtask

  task automatic test_full_job();
    run_job("full_n4", 4, 1'b0, 46);
  endtask

  task automatic test_skip_job();
    run_job("skip_n4", 4, 1'b1, 30);
  endtask

  task automatic test_overlap();
    run_job("overlap_n20", 20, 1'b0, 94);
  endtask

  task automatic expect_reject(input string name, input int n, input bit skip);
    issue(n, skip);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s cycle1 err=%b busy=%b required err=1 busy=0", name, err, busy);
    end
    @(negedge clk);
    checks++;
    if (observed() !== 10'b0) begin
      errors++;
      $display("FAIL %s cycle2 outputs=%b required 0", name, observed());
    end
  endtask

  task automatic test_reject();
    do_reset();
    expect_reject("reject_skip_no_weights", 4, 1'b1);
    expect_reject("reject_zero_rows", 0, 1'b0);
    expect_reject("reject_65_rows", 65, 1'b0);
    // abort together with a valid start drops the command silently
    issue(4, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (observed() !== 10'b0) begin
      errors++;
      $display("FAIL abort_start_idle outputs=%b required 0", observed());
    end
  endtask

  task automatic test_abort_preload();
    logic seen_done;
    issue(4, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (weight_buffer_out_en !== 1'b1 || write_weight_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_state wo=%b ww=%b required 1 1", weight_buffer_out_en, write_weight_en);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (observed() !== 10'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL abort_next_cycle outputs=%b state=%0d required 0 0", observed(), state_dbg);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got activity=%b required 0", seen_done);
    end
    expect_reject("abort_clears_weights", 4, 1'b1);
  endtask

  task automatic test_async_reset();
    issue(4, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (input_buffer_out_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_state io=%b busy=%b required 0 1", input_buffer_out_en, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (observed() !== 10'b0) begin
      errors++;
      $display("FAIL async_reset outputs=%b required 0", observed());
    end
    @(negedge clk);
    rst = 1'b1;
    expect_reject("reset_clears_weights", 4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_skip_job();
    test_reject();
    test_overlap();
    test_abort_preload();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
